pipe_issue_ctrl: RTL
====================

// Module: pipe_issue_ctrl
// PURPOSE
//  Issue controller for the 3-stage ALU/regbank pipeline. Buffers incoming instruction words in a small
//  FIFO and issues one per cycle as {func, rs1, rs2, rd, addr} to the pipeline's decode stage.
//  Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards, so sources are
//  never read before write-back. Provides start/flush sequencing and issue/stall performance counters.
// PARAMETERS
//  DEPTH   4  instruction FIFO entries (power of 2, >=2)
//  WB_LAT  3  cycles from iss_valid until the rd write is visible in the regbank (>=1)
// PORTS
//  clk         in   1   single system clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   IDLE->RUN request (level, sampled each cycle)
//  flush       in   1   abort request: discard FIFO, drain pipeline
//  in_valid    in   1   producer has an instruction on in_instr
//  in_ready    out  1   FIFO accepts; transfer when in_valid&&in_ready
//  in_instr    in   24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}
//  iss_valid   out  1   issued instruction on iss_* this cycle
//  iss_func    out  4   ALU function code 0..15 (passed through unchanged)
//  iss_rs1     out  4   source register 1
//  iss_rs2     out  4   source register 2
//  iss_rd      out  4   destination register
//  iss_addr    out  8   memory write address
//  state       out  2   0=IDLE 1=RUN 2=DRAIN
//  busy        out  1   state!=IDLE or any scoreboard entry valid
//  flush_done  out  1   one-cycle pulse when DRAIN completes
//  issue_cnt   out  16  instructions issued since reset, saturating at 16'hFFFF
//  stall_cnt   out  16  hazard-stall cycles since reset, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, scoreboard cleared, all iss_* = 0, flush_done=0, counters=0, in_ready=0.
//  Async assert takes effect immediately, including mid-issue or mid-drain; no partial instruction survives.
//  FIFO: in_ready = (count<DEPTH) && state!=DRAIN; accepts in IDLE and RUN. No bypass, so a push into an
//   empty FIFO becomes head the next cycle. When full, in_ready=0 even if a pop happens that cycle.
//   Pointers wrap modulo DEPTH.
//  Scoreboard: WB_LAT-entry shift register of {v, rd}. It shifts every cycle. Entry0 <= {issue, head.rd}.
//   The last entry drops out.
//  Hazard: head.rs1 or head.rs2 equals sb[i].rd with sb[i].v, for any i. All funcs are treated as reading
//   both sources and writing rd.
//  Issue in cycle c: when state==RUN, FIFO non-empty and no hazard, pop the head. In cycle c+1:
//   - iss_valid=1 and iss_* = decoded fields;
//   - sb[0] holds rd.
//   Otherwise iss_valid=0 at c+1 and iss_* hold their last values.
//   Peak rate is 1 issue/cycle, in order; there is no reordering around a stalled head.
//  Dependent pair: back-to-back dependent instructions show exactly WB_LAT idle cycles between their iss_valid pulses.
//  stall_cnt: +1 in every cycle with state==RUN, FIFO non-empty and hazard. issue_cnt: +1 per issue.
//  FSM:
//   - IDLE: flush -> DRAIN; else start -> RUN. If both are asserted, flush wins.
//   - RUN: flush -> DRAIN. start is ignored. An empty FIFO stays in RUN.
//   - DRAIN: on the entry edge the FIFO is emptied, no issue occurs and in_ready=0. When the scoreboard is
//     all-invalid, flush_done=1 for one cycle and the FSM -> IDLE. flush held in DRAIN has no extra effect.
//   - Flush from IDLE with an empty scoreboard: DRAIN lasts 1 cycle and then flush_done pulses.
// TESTING
//  1. Reset with in_valid=1 and start=1 held:
//     -> all outputs 0 and state=0 during rst.
//     -> state=1 on the first edge after release; in_ready=1.
//  2. RUN, 4 independent instrs (rd=1..4, sources 8..11) pushed back to back:
//     -> 4 consecutive iss_valid pulses, issue_cnt=4, stall_cnt=0.
//  3. A: rd=1. B: rs1=1, queued directly behind A.
//     -> B's iss_valid comes 4 cycles after A's, with 3 idle cycles between.
//     -> stall_cnt=3.
//  4. IDLE (no issue), push 5 instrs:
//     -> in_ready drops after the 4th and the 5th is held.
//     -> after start, all 5 issue in order and in_ready returns.
//  5. RUN, FIFO holding 3 instrs, one just issued, then flush for 1 cycle:
//     -> no further iss_valid, in_ready=0.
//     -> flush_done pulses once the last sb entry retires (<=WB_LAT+1 cycles), then state=0.
//  6. rst asserted mid-stall with 2 instrs in flight:
//     -> immediate return to reset values; after release, a fresh instruction with rs1=old rd issues with no stall.

Source files
------------

// File: rtl/pipe_issue_ctrl.sv
// Issue controller: buffers instruction words in a FIFO and issues them in order to the decode stage.
// Stalls the FIFO head while any in-flight destination register matches one of its source registers.
module pipe_issue_ctrl #(
    parameter int DEPTH  = 4,
    parameter int WB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    output logic        iss_valid,
    output logic [3:0]  iss_func,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [3:0]  iss_rd,
    output logic [7:0]  iss_addr,
    output logic [1:0]  state,
    output logic        busy,
    output logic        flush_done,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [23:0]       fifo_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic [AW:0]       count_nxt_s;
    logic [WB_LAT-1:0] sb_v_r;
    logic [3:0]        sb_rd_r [WB_LAT];
    logic [23:0]       head_s;
    logic              hazard_s;
    logic              push_s;
    logic              issue_s;
    logic              stall_s;
    logic              enter_drain_s;
    logic              nonempty_s;

    assign head_s        = fifo_r[rd_ptr_r];
    assign nonempty_s    = (count_r != {(AW + 1){1'b0}});
    assign push_s        = in_valid && in_ready;
    assign issue_s       = (state_r == RUN) && !flush && nonempty_s && !hazard_s;
    assign stall_s       = (state_r == RUN) && nonempty_s && hazard_s;
    assign enter_drain_s = (state_nxt_s == DRAIN) && (state_r != DRAIN);
    assign state         = state_r;
    assign busy          = (state_r != IDLE) || (|sb_v_r);

    // RAW check of the head's two sources against every in-flight destination
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_v_r[i] && ((sb_rd_r[i] == head_s[15:12]) || (sb_rd_r[i] == head_s[11:8]))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Next-state selection; flush has priority over start
    always_comb begin
        case (state_r)
            IDLE: begin
                if (flush) begin
                    state_nxt_s = DRAIN;
                end else if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DRAIN: begin
                if (~|sb_v_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Occupancy after this cycle's push/pop; entering DRAIN discards everything
    always_comb begin
        if (enter_drain_s) begin
            count_nxt_s = {(AW + 1){1'b0}};
        end else begin
            count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, issue_s};
        end
    end

    // FSM, FIFO storage and the registered ready/done flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= {(AW + 1){1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            in_ready   <= 1'b0;
            flush_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= 24'h000000;
            end
        end else begin
            state_r    <= state_nxt_s;
            count_r    <= count_nxt_s;
            in_ready   <= (count_nxt_s < FULL) && (state_nxt_s != DRAIN);
            flush_done <= (state_r == DRAIN) && (~|sb_v_r);
            if (enter_drain_s) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (push_s) begin
                    fifo_r[wr_ptr_r] <= in_instr;
                    wr_ptr_r         <= wr_ptr_r + AW'(1'b1);
                end
                if (issue_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
            end
        end
    end

    // Scoreboard shift register and the registered issue port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v_r    <= {WB_LAT{1'b0}};
            iss_valid <= 1'b0;
            iss_func  <= 4'd0;
            iss_rs1   <= 4'd0;
            iss_rs2   <= 4'd0;
            iss_rd    <= 4'd0;
            iss_addr  <= 8'd0;
            for (int i = 0; i < WB_LAT; i++) begin
                sb_rd_r[i] <= 4'd0;
            end
        end else begin
            sb_v_r[0]  <= issue_s;
            sb_rd_r[0] <= head_s[19:16];
            for (int i = 1; i < WB_LAT; i++) begin
                sb_v_r[i]  <= sb_v_r[i-1];
                sb_rd_r[i] <= sb_rd_r[i-1];
            end
            iss_valid <= issue_s;
            if (issue_s) begin
                iss_func <= head_s[23:20];
                iss_rd   <= head_s[19:16];
                iss_rs1  <= head_s[15:12];
                iss_rs2  <= head_s[11:8];
                iss_addr <= head_s[7:0];
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (issue_s && (issue_cnt != 16'hFFFF)) begin
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (stall_s && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule
